// File: rtl/quad_step_decoder_pkg.sv
// Shared definitions for the quadrature step decoder: FSM encodings, Gray-order phase
// constants and the phase-transition classifier.
package quad_step_decoder_pkg;

   localparam logic INIT  = 1'b0;
   localparam logic TRACK = 1'b1;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam int unsigned INIT_LEN = 3;

   typedef enum logic [1:0] {
      StepNone,
      StepFwd,
      StepRev,
      StepIllegal
   } step_e;

   function automatic logic [1:0] fwd_next(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         PH_00:   n = PH_01;
         PH_01:   n = PH_11;
         PH_11:   n = PH_10;
         default: n = PH_00;
      endcase
      return n;
   endfunction

   // Any change that is neither neighbour flips both bits at once.
   function automatic step_e classify(input logic [1:0] p, input logic [1:0] n);
      step_e s;
      if (n == p) begin
         s = StepNone;
      end else if (n == fwd_next(p)) begin
         s = StepFwd;
      end else if (p == fwd_next(n)) begin
         s = StepRev;
      end else begin
         s = StepIllegal;
      end
      return s;
   endfunction

endpackage

// File: rtl/quad_step_decoder_input_filter.sv
// Two-flop synchronizer followed by a stability-count glitch filter for one phase input.
module quad_step_decoder_input_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic Clk,
   input  logic nReset,
   input  logic bypass,
   input  logic din,
   output logic dout
);

   logic       sync1_q;
   logic       sync2_q;
   logic       filt_q;
   logic [3:0] cnt_q;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         if (bypass) begin
            filt_q <= sync2_q;
            cnt_q  <= 4'd0;
         end else if (sync2_q == filt_q) begin
            cnt_q <= 4'd0;
         end else if (32'(cnt_q) + 32'd1 >= FILTER_LEN) begin
            filt_q <= sync2_q;
            cnt_q  <= 4'd0;
         end else begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

   // While bypassed the synchronized value is seen the same cycle, so the phase
   // register is already aligned when tracking starts.
   assign dout = bypass ? sync2_q : filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: filters A/B, tracks Gray phase and emits one-cycle count pulses
// with direction for a falling-edge up/down counter.
module quad_step_decoder
   import quad_step_decoder_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       A,
   input  logic       B,
   input  logic       Step_en,
   input  logic       Clr_err,
   output logic       Count_en,
   output logic       Up,
   output logic       Err,
   output logic [1:0] Phase
);

   logic       state_q;
   logic [1:0] init_cnt_q;
   logic       bypass;
   logic       a_filt;
   logic       b_filt;
   logic [1:0] new_phase;
   step_e      step;

   assign bypass    = (state_q == INIT);
   assign new_phase = {a_filt, b_filt};
   assign step      = classify(Phase, new_phase);

   quad_step_decoder_input_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_filt_a (
      .Clk   (Clk),
      .nReset(nReset),
      .bypass(bypass),
      .din   (A),
      .dout  (a_filt)
   );

   quad_step_decoder_input_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_filt_b (
      .Clk   (Clk),
      .nReset(nReset),
      .bypass(bypass),
      .din   (B),
      .dout  (b_filt)
   );

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= INIT;
         init_cnt_q <= 2'd0;
         Count_en   <= 1'b0;
         Up         <= 1'b0;
         Err        <= 1'b0;
         Phase      <= PH_00;
      end else begin
         Phase    <= new_phase;
         Count_en <= 1'b0;
         if (state_q == INIT) begin
            if (init_cnt_q == 2'(INIT_LEN - 1)) begin
               state_q <= TRACK;
            end else begin
               init_cnt_q <= init_cnt_q + 2'd1;
            end
            if (Clr_err) begin
               Err <= 1'b0;
            end
         end else begin
            unique case (step)
               StepNone: ;
               StepFwd: begin
                  Up       <= 1'b1;
                  Count_en <= Step_en;
               end
               StepRev: begin
                  Up       <= 1'b0;
                  Count_en <= Step_en;
               end
               StepIllegal: ;
               default: ;
            endcase
            // Set has priority over a simultaneous clear.
            if (step == StepIllegal) begin
               Err <= 1'b1;
            end else if (Clr_err) begin
               Err <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed table-driven bench for quad_step_decoder with a downstream 4-bit counter model.
module tb_quad_step_decoder;

   logic       Clk = 1'b0;
   logic       nReset;
   logic       A;
   logic       B;
   logic       Step_en;
   logic       Clr_err;
   logic       Count_en;
   logic       Up;
   logic       Err;
   logic [1:0] Phase;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int doubles = 0;
   logic prev_ce = 1'b0;
   logic [3:0] model_cnt = 4'd0;

   always #5 Clk = ~Clk;

   quad_step_decoder #(
      .FILTER_LEN(3)
   ) dut (
      .Clk     (Clk),
      .nReset  (nReset),
      .A       (A),
      .B       (B),
      .Step_en (Step_en),
      .Clr_err (Clr_err),
      .Count_en(Count_en),
      .Up      (Up),
      .Err     (Err),
      .Phase   (Phase)
   );

   typedef struct {
      logic       a;
      logic       b;
      logic       en;
      logic       clr_cnt;
      int         hold;
      int         exp_pulses;
      logic       exp_up;
      logic       exp_err;
      logic [1:0] exp_phase;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Sample 1 time unit after the rising edge; model a counter that samples Count_en/Up.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (Count_en === 1'b1) begin
         pulses++;
         if (prev_ce) doubles++;
         model_cnt = (Up === 1'b1) ? model_cnt + 4'd1 : model_cnt - 4'd1;
      end
      prev_ce = (Count_en === 1'b1);
   endtask

   task automatic run_rows(input int first, input int last);
      int p0;
      int d0;
      for (int i = first; i <= last; i++) begin
         if (vecs[i].clr_cnt) model_cnt = 4'd0;
         A       = vecs[i].a;
         B       = vecs[i].b;
         Step_en = vecs[i].en;
         p0      = pulses;
         d0      = doubles;
         for (int t = 0; t < vecs[i].hold; t++) tick();
         chk($sformatf("row%0d pulses", i), pulses - p0, vecs[i].exp_pulses);
         chk($sformatf("row%0d width", i), doubles - d0, 0);
         chk($sformatf("row%0d up", i), int'(Up), int'(vecs[i].exp_up));
         chk($sformatf("row%0d err", i), int'(Err), int'(vecs[i].exp_err));
         chk($sformatf("row%0d phase", i), int'(Phase), int'(vecs[i].exp_phase));
         chk($sformatf("row%0d counter", i), int'(model_cnt), vecs[i].exp_cnt);
      end
   endtask

   initial begin
      int p0;
      //          a     b     en    clr   hold pul up    err   phase  cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8,  1, 1'b1, 1'b0, 2'b10, 1};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8,  1, 1'b1, 1'b0, 2'b00, 2};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8,  1, 1'b1, 1'b0, 2'b01, 1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8,  1, 1'b1, 1'b0, 2'b11, 2};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8,  1, 1'b1, 1'b0, 2'b10, 3};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8,  1, 1'b1, 1'b0, 2'b00, 4};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8,  1, 1'b0, 1'b0, 2'b10, 15};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8,  1, 1'b0, 1'b0, 2'b11, 14};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8,  1, 1'b0, 1'b0, 2'b01, 13};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8,  1, 1'b0, 1'b0, 2'b00, 12};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2,  0, 1'b0, 1'b0, 2'b00, 12};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8,  0, 1'b0, 1'b0, 2'b00, 12};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 5,  0, 1'b0, 1'b0, 2'b00, 12};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2, 1'b1, 1'b0, 2'b00, 12};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 8,  0, 1'b1, 1'b1, 2'b11, 12};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8,  1, 1'b0, 1'b0, 2'b10, 11};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  0, 1'b1, 1'b0, 2'b00, 11};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8,  0, 1'b1, 1'b0, 2'b01, 11};

      nReset  = 1'b0;
      A       = 1'b1;
      B       = 1'b1;
      Step_en = 1'b1;
      Clr_err = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      chk("reset count_en", int'(Count_en), 0);
      chk("reset up", int'(Up), 0);
      chk("reset err", int'(Err), 0);
      chk("reset phase", int'(Phase), 0);

      // Release with both phases high: INIT must absorb 11 without a step or error.
      nReset = 1'b1;
      p0 = pulses;
      for (int t = 0; t < 10; t++) tick();
      chk("init pulses", pulses - p0, 0);
      chk("init phase", int'(Phase), 3);
      chk("init err", int'(Err), 0);

      run_rows(0, 14);

      // 11 -> 00 is illegal; Clr_err coincides with the edge that sets Err.
      A = 1'b0;
      B = 1'b0;
      p0 = pulses;
      for (int t = 0; t < 5; t++) tick();
      Clr_err = 1'b1;
      tick();
      Clr_err = 1'b0;
      chk("set beats clr err", int'(Err), 1);
      chk("illegal2 phase", int'(Phase), 0);
      for (int t = 0; t < 2; t++) tick();
      chk("illegal2 pulses", pulses - p0, 0);
      chk("err sticky", int'(Err), 1);
      Clr_err = 1'b1;
      tick();
      Clr_err = 1'b0;
      chk("clr err", int'(Err), 0);

      run_rows(15, 17);

      // Latency: change after edge j gives Count_en high after edge j+6.
      Step_en = 1'b1;
      A = 1'b1;
      B = 1'b1;
      for (int t = 0; t < 5; t++) tick();
      chk("latency t5 count_en", int'(Count_en), 0);
      chk("latency t5 phase", int'(Phase), 1);
      tick();
      chk("latency t6 count_en", int'(Count_en), 1);
      chk("latency t6 up", int'(Up), 1);
      chk("latency t6 phase", int'(Phase), 3);
      tick();
      chk("latency t7 count_en", int'(Count_en), 0);

      // Reset in the middle of filtering a reverse step.
      A = 1'b0;
      tick();
      tick();
      tick();
      nReset = 1'b0;
      #1;
      chk("midreset count_en", int'(Count_en), 0);
      chk("midreset up", int'(Up), 0);
      chk("midreset err", int'(Err), 0);
      chk("midreset phase", int'(Phase), 0);
      tick();
      tick();
      nReset = 1'b1;
      p0 = pulses;
      for (int t = 0; t < 10; t++) tick();
      chk("postreset pulses", pulses - p0, 0);
      chk("postreset phase", int'(Phase), 1);
      chk("postreset err", int'(Err), 0);
      chk("postreset up", int'(Up), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature step decoder that drives the control inputs of the 4-bit up/down counter. It samples two asynchronous phase inputs (A, B) from a rotary encoder or stepper feedback. It synchronizes and glitch-filters them, then tracks the Gray-code phase. For each legal quarter-step it emits a one-cycle `Count_en` pulse, with `Up` giving the direction. It runs on the rising edge of `Clk`, so its outputs are settled before the counter samples on the falling edge.

## Interface
- `FILTER_LEN`, default 3: consecutive cycles a synchronized input must hold a new value before it is accepted. Legal range 1..15.
- `Clk` input 1: system clock; all state updates on the rising edge.
- `nReset` input 1: reset, asynchronous, active-low.
- `A` input 1: phase A; asynchronous to `Clk`.
- `B` input 1: phase B; asynchronous to `Clk`.
- `Step_en` input 1: when high, legal steps produce pulses; when low, phase is tracked but no pulses are emitted.
- `Clr_err` input 1: synchronous clear of `Err`.
- `Count_en` output 1: one-cycle pulse per accepted step.
- `Up` output 1: direction of the most recent accepted step; 1 = forward.
- `Err` output 1: sticky flag for an illegal two-bit phase jump.
- `Phase` output 2: current filtered phase {A,B}.

## Operation
**Synchronizer**
- Two flops per input; both reset to 0.

**Glitch filter**
- Each input has a stability counter, 4 bits wide.
- When the synchronized value differs from the filtered value, the counter increments.
- When the values match, the counter clears.
- When the counter reaches `FILTER_LEN`, the filtered bit takes the synchronized value and the counter clears.

**FSM states**
- `INIT`: entered on reset.
  - Filtered bits follow the synchronized bits every cycle, bypassing the filter.
  - No pulses are emitted.
  - After 3 cycles, move to `TRACK`.
  - This prevents a spurious step or error when A/B are nonzero at reset release.
- `TRACK`: normal decoding.
- There are no other states.

**Step decode in `TRACK`**
- Compare the previous filtered phase P with the new filtered phase N each cycle.
- Forward order: 00→01→11→10→00.
- N equal to P: no action.
- N is P's forward neighbour:
  - `Up` is set to 1.
  - `Count_en` pulses if `Step_en` is high.
- N is P's reverse neighbour:
  - `Up` is set to 0.
  - `Count_en` pulses if `Step_en` is high.
- Both bits change in the same cycle:
  - `Err` is set.
  - No pulse is emitted and `Up` is unchanged.
  - `Phase` still adopts N, so tracking resynchronizes.
- `Up` is updated even when `Step_en` is low.
- `Up` holds its value between steps.

**Err**
- Set and clear requested in the same cycle: set wins.
- Otherwise `Clr_err` clears `Err`.

**Reset values**
- `Count_en`=0, `Up`=0, `Err`=0, `Phase`=00.
- Filter counters 0; FSM in `INIT`.
- An asynchronous reset asserted mid-step discards any partially filtered edge.

## Timing
- Latency: an A/B edge settled before rising edge k gives `Count_en` high during the cycle after edge k+2+`FILTER_LEN`. That is `FILTER_LEN`+3 cycles.
- `Count_en` is high for exactly one cycle.
- `Up` changes on the same edge that raises `Count_en` and is stable through the counter's falling-edge sample.
- Pulses below `FILTER_LEN` cycles are rejected with no output.
- Maximum step rate: one step per `FILTER_LEN`+1 cycles per input.
- `Phase` and `Err` update on the same edge as `Count_en`.

## Structure
- Shared constants file (`quad_step_defs`) holds:
  - FSM state encodings: `INIT`, `TRACK`.
  - Gray-order phase constants: 00, 01, 11, 10.
  - `INIT` hold length: 3.
- Natural sub-module: `input_filter`, one instance per input. It contains the 2-flop synchronizer and the stability counter, with parameter `FILTER_LEN`, inputs `Clk`/`nReset`/`bypass`/`din`, and output `dout`.
- Top level contains the FSM, step decode and output registers.

## Test plan
All scenarios use `FILTER_LEN`=3.
1. Reset released with A=1, B=1; wait 10 cycles → `Phase`=11, `Err`=0, no `Count_en`.
2. From phase 00, drive 01, 11, 10, 00, each held 8 cycles, `Step_en`=1 → exactly 4 one-cycle `Count_en` pulses, each 6 cycles after its input change, `Up`=1. A downstream counter started at 0 reads 4.
3. Reverse sequence 00, 10, 11, 01, 00 → 4 pulses with `Up`=0; counter wraps 0→15→14→13→12.
4. 2-cycle glitch on A, then a 5-cycle A pulse → first produces nothing; second produces one forward step and one reverse step.
5. A and B toggled on the same edge (00→11) → `Err`=1, no pulse, `Phase`=11. `Clr_err` asserted alongside a second illegal jump leaves `Err`=1; `Clr_err` alone clears it.
6. `Step_en`=0 during two forward steps → no pulses, `Phase` tracks, `Up`=1. Asserting `nReset`=0 mid-filter → all outputs return to reset values immediately.
